// File: rtl/core2axi4l.sv
// Bridges a core memory port (req/gnt/rvalid) to an AXI4-Lite master.
// At most one transaction is outstanding; AW and W channels complete independently.
module core2axi4l #(
  parameter logic [2:0] AXPROT = 3'b000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StResp
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        core_rvalid_q;

  logic aw_done_d;
  logic w_done_d;

  // A channel counts as done once its handshake has happened, this cycle or earlier.
  assign aw_done_d = aw_done_q | (awvalid_q & awready);
  assign w_done_d  = w_done_q | (wvalid_q & wready);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StIdle;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      be_q          <= 4'h0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= 32'h0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      core_rvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (core_req) begin
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
            be_q    <= core_be;
            if (core_we) begin
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrReq;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdAddr;
            end
          end
        end
        StRdAddr: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (rvalid) begin
            rdata_q       <= rdata;
            err_q         <= (rresp != 2'b00);
            rready_q      <= 1'b0;
            core_rvalid_q <= 1'b1;
            state_q       <= StResp;
          end
        end
        StWrReq: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready) wvalid_q <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (bvalid) begin
            err_q         <= (bresp != 2'b00);
            bready_q      <= 1'b0;
            core_rvalid_q <= 1'b1;
            state_q       <= StResp;
          end
        end
        StResp: begin
          core_rvalid_q <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grant is suppressed while reset is asserted so nothing is accepted during it.
  assign core_gnt    = core_req & (state_q == StIdle) & ~areset;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = rdata_q;
  assign core_err    = core_rvalid_q & err_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awprot  = AXPROT;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = be_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arprot  = AXPROT;
  assign rready  = rready_q;

endmodule

// File: tb/tb_core2axi4l.sv
// Directed self-checking bench for core2axi4l with a hand-driven AXI4-Lite slave.
module tb_core2axi4l;

  logic        aclk = 1'b0;
  logic        areset;
  logic        core_req;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  core2axi4l #(
    .AXPROT(3'b000)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awprot     (awprot),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .bvalid     (bvalid),
    .bready     (bready),
    .bresp      (bresp),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arprot     (arprot),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check_val({tag, " valids"}, 32'({awvalid, wvalid, bready, arvalid, rready, core_rvalid}),
              32'd0);
  endtask

  // Zero-wait read; returns captured data/err and cycles from gnt to core_rvalid.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] rd, input logic [1:0] rr,
                          output logic [31:0] got_data, output logic got_err, output int lat);
    core_req = 1'b1; core_we = 1'b0; core_addr = addr;
    arready = 1'b1; rvalid = 1'b1; rdata = rd; rresp = rr;
    #1;
    check_val("rd gnt", 32'(core_gnt), 32'd1);
    tick();
    core_req = 1'b0;
    lat = 1;
    while (!core_rvalid && lat < 20) begin
      tick();
      lat++;
    end
    got_data = core_rdata;
    got_err  = core_err;
    tick();
    arready = 1'b0; rvalid = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                           input logic [1:0] br, output logic got_err, output int lat);
    core_req = 1'b1; core_we = 1'b1; core_addr = addr; core_wdata = wd; core_be = be;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = br;
    #1;
    check_val("wr gnt", 32'(core_gnt), 32'd1);
    tick();
    core_req = 1'b0;
    lat = 1;
    while (!core_rvalid && lat < 20) begin
      tick();
      lat++;
    end
    got_err = core_err;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          first_rv;
    int          second_gnt;
    int          overlap;

    areset = 1'b1; core_req = 1'b1; core_we = 1'b0; core_be = 4'h0;
    core_addr = 32'h0; core_wdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

    // Reset state
    tick();
    tick();
    check_val("rst gnt", 32'(core_gnt), 32'd0);
    check_idle_outs("rst");
    check_val("rst err", 32'(core_err), 32'd0);
    check_val("rst rdata", core_rdata, 32'h0);
    check_val("prot", 32'({awprot, arprot}), 32'd0);
    core_req = 1'b0;
    areset = 1'b0;
    tick();
    check_idle_outs("post rst");

    // Zero-wait read, cycle by cycle
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_1000;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    #1;
    check_val("r0 gnt", 32'(core_gnt), 32'd1);
    tick();
    core_req = 1'b0;
    check_val("r1 arvalid", 32'(arvalid), 32'd1);
    check_val("r1 araddr", araddr, 32'h0000_1000);
    check_val("r1 rready", 32'(rready), 32'd0);
    tick();
    check_val("r2 arvalid", 32'(arvalid), 32'd0);
    check_val("r2 rready", 32'(rready), 32'd1);
    tick();
    check_val("r3 rvalid", 32'(core_rvalid), 32'd1);
    check_val("r3 rdata", core_rdata, 32'hDEAD_BEEF);
    check_val("r3 err", 32'(core_err), 32'd0);
    tick();
    check_val("r4 rvalid", 32'(core_rvalid), 32'd0);
    arready = 1'b0; rvalid = 1'b0;

    // Write with W accepted three cycles before AW
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20;
    core_wdata = 32'h1234_5678; core_be = 4'b0011;
    wready = 1'b1;
    #1;
    check_val("w0 gnt", 32'(core_gnt), 32'd1);
    tick();
    core_req = 1'b0;
    check_val("w1 aw/w valid", 32'({awvalid, wvalid}), 32'b11);
    check_val("w1 awaddr", awaddr, 32'h20);
    check_val("w1 wdata", wdata, 32'h1234_5678);
    check_val("w1 wstrb", 32'(wstrb), 32'h3);
    tick();
    wready = 1'b0;
    check_val("w2 aw/w valid", 32'({awvalid, wvalid}), 32'b10);
    tick();
    check_val("w3 aw/w valid", 32'({awvalid, wvalid}), 32'b10);
    tick();
    check_val("w4 awvalid", 32'(awvalid), 32'd1);
    check_val("w4 bready", 32'(bready), 32'd0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check_val("w5 aw/w valid", 32'({awvalid, wvalid}), 32'b00);
    check_val("w5 bready", 32'(bready), 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    check_val("w6 rvalid", 32'(core_rvalid), 32'd1);
    check_val("w6 err", 32'(core_err), 32'd0);
    check_val("w6 rdata kept", core_rdata, 32'hDEAD_BEEF);
    check_val("w6 bready", 32'(bready), 32'd0);
    tick();

    // Error responses
    run_read(32'h40, 32'hCAFE_0001, 2'b10, d, e, lat);
    check_val("slverr rd err", 32'(e), 32'd1);
    check_val("slverr rd data", d, 32'hCAFE_0001);
    check_val("rd latency", 32'(lat), 32'd3);
    run_read(32'h44, 32'h0000_0011, 2'b01, d, e, lat);
    check_val("exokay rd err", 32'(e), 32'd1);
    run_write(32'h48, 32'hFFFF_0000, 4'hF, 2'b11, e, lat);
    check_val("decerr wr err", 32'(e), 32'd1);
    check_val("wr latency", 32'(lat), 32'd3);
    check_val("wr rdata kept", core_rdata, 32'h0000_0011);
    check_val("err dropped", 32'(core_err), 32'd0);
    run_write(32'h4C, 32'h0, 4'h0, 2'b00, e, lat);
    check_val("strb0 wr err", 32'(e), 32'd0);
    check_val("strb0 wr latency", 32'(lat), 32'd3);

    // Back-to-back reads with core_req held high
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h80;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b00;
    first_rv = -1; second_gnt = -1; overlap = 0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      if (core_gnt && core_rvalid) overlap++;
      if (core_rvalid && first_rv < 0) first_rv = c;
      if (core_gnt && c > 0 && second_gnt < 0) second_gnt = c;
    end
    core_req = 1'b0;
    check_val("b2b first rvalid", 32'(first_rv), 32'd3);
    check_val("b2b second gnt", 32'(second_gnt), 32'd4);
    check_val("b2b overlap", 32'(overlap), 32'd0);
    tick();
    arready = 1'b0; rvalid = 1'b0;
    tick();

    // arready stall: request stays presented, nothing else happens
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_ABC0;
    #1;
    check_val("stall gnt", 32'(core_gnt), 32'd1);
    tick();
    core_addr = 32'h0000_0FF0;
    for (int c = 1; c <= 10; c++) begin
      check_val($sformatf("stall c%0d arvalid", c), 32'(arvalid), 32'd1);
      check_val($sformatf("stall c%0d araddr", c), araddr, 32'h0000_ABC0);
      check_val($sformatf("stall c%0d gnt/rvalid", c), 32'({core_gnt, core_rvalid}), 32'd0);
      if (c < 10) tick();
    end
    core_req = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h5555_AAAA; rresp = 2'b00;
    tick();
    arready = 1'b0;
    check_val("stall rready", 32'(rready), 32'd1);
    tick();
    rvalid = 1'b0;
    check_val("stall rvalid", 32'(core_rvalid), 32'd1);
    check_val("stall rdata", core_rdata, 32'h5555_AAAA);
    tick();

    // Reset while waiting in the read-data phase
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; arready = 1'b1;
    tick();
    core_req = 1'b0;
    tick();
    arready = 1'b0;
    check_val("mid rready", 32'(rready), 32'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_idle_outs("mid rst");
    check_val("mid rst rdata", core_rdata, 32'h0);
    rvalid = 1'b1; rdata = 32'h0000_0077; rresp = 2'b00;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val($sformatf("late rvalid c%0d", c), 32'({core_rvalid, rready}), 32'd0);
    end
    check_val("late rdata", core_rdata, 32'h0);
    rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core2axi4l.md
CORE2AXI4L -- requirements
Module: core2axi4l

Interface
REQ-001 SHALL have parameter AXPROT, default 3'b000, driven unchanged on awprot and arprot.
REQ-002 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-003 SHALL have these ports:
- aclk  in  1  clock; all state changes on rising edge
- areset  in  1  synchronous active-high reset
- core_req  in  1  core request
- core_we  in  1  1=write, 0=read
- core_be  in  4  byte enables
- core_addr  in  32  byte address
- core_wdata  in  32  write data
- core_gnt  out  1  request accepted
- core_rvalid  out  1  response pulse, reads and writes
- core_rdata  out  32  read data
- core_err  out  1  error, qualified by core_rvalid
- awvalid/awready  out/in  1  AXI write address handshake
- awaddr  out  32;  awprot  out  3
- wvalid/wready  out/in  1  AXI write data handshake
- wdata  out  32;  wstrb  out  4
- bvalid/bready  in/out  1;  bresp  in  2
- arvalid/arready  out/in  1;  araddr  out  32;  arprot  out  3
- rvalid/rready  in/out  1;  rdata  in  32;  rresp  in  2

Function
REQ-004 SHALL be an AXI4-Lite master serving a core memory slave port, at most one transaction outstanding.
REQ-005 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
REQ-006 core_gnt SHALL equal core_req AND state==IDLE (combinational); other states: 0.
REQ-007 On grant SHALL register addr, we, be, wdata; next state RD_ADDR if we=0, else WR_REQ.
REQ-008 RD_ADDR: arvalid=1, araddr=registered addr; on arready -> RD_DATA.
REQ-009 RD_DATA: rready=1; on rvalid capture rdata, err=(rresp!=2'b00) -> RESP.
REQ-010 WR_REQ: awvalid and wvalid asserted independently; each deasserts in the cycle after its own handshake; leave WR_REQ in the cycle both handshakes are done (same-cycle or either order) -> WR_RESP.
REQ-011 AW/W done flags SHALL be cleared on entry to WR_REQ.
REQ-012 wdata/wstrb = registered wdata/be; wstrb=4'h0 still issues a write.
REQ-013 WR_RESP: bready=1; on bvalid capture err=(bresp!=2'b00) -> RESP.
REQ-014 RESP: core_rvalid=1 for exactly one cycle, core_err=captured err, then IDLE.
REQ-015 core_rdata SHALL hold last captured read data; unchanged by writes.
REQ-016 No grant in RESP; earliest new gnt is the cycle after core_rvalid.
REQ-017 Valid outputs SHALL hold stable until handshake, independent of ready (no combinational ready->valid path).
REQ-018 Min read latency: gnt cycle 0, arvalid cycle 1, rready cycle 2, core_rvalid cycle 3 with zero-wait slave.
REQ-019 Min write latency: gnt cycle 0, awvalid/wvalid cycle 1, bready cycle 2, core_rvalid cycle 3.
REQ-020 core_req deassertion or change after gnt SHALL NOT affect the outstanding transaction.
REQ-021 rvalid/bvalid outside RD_DATA/WR_RESP SHALL be ignored (ready=0).
REQ-022 DECERR and SLVERR both map to core_err=1; EXOKAY (2'b01) also maps to 1.

Reset
REQ-023 areset SHALL force state IDLE, clear AW/W done flags, err, core_rdata to 0.
REQ-024 During and after reset: core_gnt, core_rvalid, core_err, awvalid, wvalid, bready, arvalid, rready = 0.
REQ-025 Reset mid-transaction SHALL abandon it: no core_rvalid issued for it, valids drop at next edge.

Verification
REQ-026 Read, zero-wait slave: req addr 0x0000_1000 we=0, rdata 0xDEAD_BEEF rresp 00 -> araddr 0x1000 cycle 1, core_rvalid cycle 3, core_rdata 0xDEAD_BEEF, err 0.
REQ-027 Write, wready 3 cycles before awready: addr 0x20, wdata 0x1234_5678, be 4'b0011 -> wvalid drops after W handshake, awvalid held, WR_RESP after AW, core_rvalid err 0 after bvalid.
REQ-028 Error: read rresp 2'b10 -> core_err=1; write bresp 2'b11 -> core_err=1; core_rdata on write unchanged.
REQ-029 Back-to-back: core_req held high over two reads -> second gnt exactly the cycle after first core_rvalid, never concurrent.
REQ-030 arready held low 10 cycles -> arvalid/araddr stable all 10 cycles, no gnt, no core_rvalid.
REQ-031 areset in RD_DATA -> next cycle all valids/readies 0, later rvalid ignored, no core_rvalid.
